// File: rtl/fetch_stage.sv
// IF stage: owns the fetch PC, issues single-outstanding imem requests and buffers
// returned words with their PC in a small FIFO feeding the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] pc_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [31:0]   pc, pc_nxt, req_pc;
  logic [31:0]   redir_target;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   buf_instr [DEPTH];
  logic [31:0]   buf_pc    [DEPTH];
  logic          inflight, credit, req_fire, push, pop;

  assign redir_target   = redirect_pc & ~32'd3;
  assign inflight       = (state == S_WAIT) || (state == S_DRAIN);
  assign credit         = (count + CW'(inflight)) < CW'(DEPTH);
  assign imem_req_valid = (state == S_REQ) && credit;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign push           = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign if_valid       = (count != '0);
  assign pop            = if_valid && id_ready && !redirect_valid;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      S_IDLE:  state_nxt = S_REQ;
      S_REQ:   if (req_fire) begin
                 state_nxt = S_WAIT;
                 pc_nxt    = pc + 32'd4;
               end
      S_WAIT:  if (imem_rsp_valid) state_nxt = S_REQ;
      S_DRAIN: if (imem_rsp_valid) state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
    // A redirect overrides the PC; a request already on the bus must have its word squashed.
    if (redirect_valid) begin
      pc_nxt = redir_target;
      case (state)
        S_REQ:   if (req_fire) state_nxt = S_DRAIN;
        S_WAIT:  if (!imem_rsp_valid) state_nxt = S_DRAIN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (req_fire) req_pc <= pc;
      if (redirect_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= imem_rsp_data;
      buf_pc[wr_ptr]    <= req_pc;
    end
  end

  assign if_instr    = if_valid ? buf_instr[rd_ptr] : NOP;
  assign if_pc       = if_valid ? buf_pc[rd_ptr] : '0;
  assign if_pc_plus4 = if_pc + 32'd4;
  assign pc_out      = pc;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset) push |-> (count < CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// checked against an architectural model of the delivered PC stream.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] pc_out;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .pc_out(pc_out)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; logic [31:0] plus4; } pop_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned ready_pct = 100;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  int unsigned lat_q[$];
  logic [31:0] acc_q[$];
  pop_t        pop_q[$];
  logic        hs = 1'b0;
  logic [31:0] hs_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog expired");
  end

  // Sampler: handshakes and pops are observed mid-cycle, away from the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      hs      = reset && imem_req_valid && imem_req_ready;
      hs_addr = imem_req_addr;
      if (reset && if_valid && id_ready && !redirect_valid)
        pop_q.push_back('{pc: if_pc, instr: if_instr, plus4: if_pc_plus4});
    end
  end

  // Memory: one response per accepted request, k cycles after the accept cycle.
  initial begin
    bit          pending;
    int unsigned cnt;
    logic [31:0] pend_addr;
    pending = 0; cnt = 0; pend_addr = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    forever begin
      @(posedge clk); #2;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (!reset) begin
        pending = 0;
        hs      = 1'b0;
      end else begin
        if (hs) begin
          acc_q.push_back(hs_addr);
          pending   = 1;
          pend_addr = hs_addr;
          cnt       = (lat_q.size() != 0) ? lat_q.pop_front() : $urandom_range(lat_max, lat_min);
          hs        = 1'b0;
        end
        if (pending) begin
          cnt--;
          if (cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr);
            pending        = 0;
          end
        end
      end
      imem_req_ready = ($urandom_range(99, 0) < ready_pct);
    end
  end

  task automatic do_reset(input logic idr);
    @(posedge clk); #1;
    reset = 1'b0; redirect_valid = 1'b0; id_ready = idr;
    lat_min = 1; lat_max = 1; ready_pct = 100; lat_q.delete();
    repeat (2) @(posedge clk);
    #1;
    acc_q.delete(); pop_q.delete();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
    n_cmp++; if (if_instr !== NOP) begin n_bad++; $display("FAIL reset_if_instr: got %h want %h", if_instr, NOP); end
    n_cmp++; if (if_pc !== 32'h0) begin n_bad++; $display("FAIL reset_if_pc: got %h want 0", if_pc); end
    n_cmp++; if (pc_out !== RESET_PC) begin n_bad++; $display("FAIL reset_pc_out: got %h want %h", pc_out, RESET_PC); end
    @(posedge clk); #1;
    acc_q.delete(); pop_q.delete();
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL idle_req_valid: got %b want 0", imem_req_valid); end
    @(negedge clk);
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL first_req_valid: got %b want 1", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== RESET_PC) begin n_bad++; $display("FAIL first_req_addr: got %h want %h", imem_req_addr, RESET_PC); end
  endtask

  task automatic test_sequential();
    logic [31:0] e;
    do_reset(1'b1);
    for (int i = 0; i < 100 && pop_q.size() < 3; i++) @(negedge clk);
    n_cmp++; if (pop_q.size() < 3) begin n_bad++; $display("FAIL seq_pop_count: got %0d want >=3", pop_q.size()); end
    for (int i = 0; i < 3; i++) begin
      e = RESET_PC + 32'(4 * i);
      if (acc_q.size() > i) begin
        n_cmp++; if (acc_q[i] !== e) begin n_bad++; $display("FAIL seq_req_addr[%0d]: got %h want %h", i, acc_q[i], e); end
      end
      if (pop_q.size() > i) begin
        n_cmp++; if (pop_q[i].pc !== e) begin n_bad++; $display("FAIL seq_if_pc[%0d]: got %h want %h", i, pop_q[i].pc, e); end
        n_cmp++; if (pop_q[i].instr !== mem_word(e)) begin n_bad++; $display("FAIL seq_if_instr[%0d]: got %h want %h", i, pop_q[i].instr, mem_word(e)); end
        n_cmp++; if (pop_q[i].plus4 !== e + 32'd4) begin n_bad++; $display("FAIL seq_pc_plus4[%0d]: got %h want %h", i, pop_q[i].plus4, e + 32'd4); end
      end
    end
  endtask

  task automatic test_stall();
    do_reset(1'b0);
    repeat (5) @(negedge clk);
    n_cmp++; if (if_pc !== RESET_PC) begin n_bad++; $display("FAIL stall_head_early: got %h want %h", if_pc, RESET_PC); end
    repeat (5) @(negedge clk);
    n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL stall_if_valid: got %b want 1", if_valid); end
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL stall_req_valid: got %b want 0", imem_req_valid); end
    n_cmp++; if (acc_q.size() != DEPTH) begin n_bad++; $display("FAIL stall_buffered: got %0d want %0d", acc_q.size(), DEPTH); end
    n_cmp++; if (if_pc !== RESET_PC) begin n_bad++; $display("FAIL stall_head_pc: got %h want %h", if_pc, RESET_PC); end
    n_cmp++; if (if_instr !== mem_word(RESET_PC)) begin n_bad++; $display("FAIL stall_head_instr: got %h want %h", if_instr, mem_word(RESET_PC)); end
    @(posedge clk); #1;
    id_ready = 1'b1;
    for (int i = 0; i < 100 && pop_q.size() < 3; i++) @(negedge clk);
    n_cmp++; if (pop_q.size() < 3) begin n_bad++; $display("FAIL stall_pop_count: got %0d want >=3", pop_q.size()); end
    for (int i = 0; i < 3; i++) if (pop_q.size() > i) begin
      n_cmp++; if (pop_q[i].pc !== RESET_PC + 32'(4 * i)) begin n_bad++; $display("FAIL stall_drain_pc[%0d]: got %h want %h", i, pop_q[i].pc, RESET_PC + 32'(4 * i)); end
    end
    n_cmp++; if (acc_q.size() < 3 || acc_q[2] !== RESET_PC + 32'd8) begin n_bad++; $display("FAIL stall_resume_addr: got n=%0d want addr %h", acc_q.size(), RESET_PC + 32'd8); end
  endtask

  task automatic test_redirect_drain();
    do_reset(1'b1);
    lat_q = '{1, 1, 5};
    for (int i = 0; i < 100 && acc_q.size() < 3; i++) @(negedge clk);
    n_cmp++; if (acc_q.size() != 3) begin n_bad++; $display("FAIL drain_setup_accepts: got %0d want 3", acc_q.size()); end
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL drain_req_valid: got %b want 0", imem_req_valid); end
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL drain_if_valid: got %b want 0", if_valid); end
    for (int i = 0; i < 100 && pop_q.size() < 3; i++) @(negedge clk);
    n_cmp++; if (pop_q.size() < 3 || pop_q[2].pc !== 32'h100) begin n_bad++; $display("FAIL drain_if_pc: got n=%0d want third pc 00000100", pop_q.size()); end
    n_cmp++; if (pop_q.size() < 3 || pop_q[2].instr !== mem_word(32'h100)) begin n_bad++; $display("FAIL drain_if_instr: got n=%0d want %h", pop_q.size(), mem_word(32'h100)); end
    n_cmp++; if (acc_q.size() < 4 || acc_q[3] !== 32'h100) begin n_bad++; $display("FAIL drain_next_addr: got n=%0d want 00000100", acc_q.size()); end
  endtask

  task automatic test_redirect_same_rsp();
    do_reset(1'b1);
    lat_q = '{1, 1, 3};
    for (int i = 0; i < 100 && acc_q.size() < 3; i++) @(negedge clk);
    n_cmp++; if (acc_q.size() != 3) begin n_bad++; $display("FAIL samersp_setup_accepts: got %0d want 3", acc_q.size()); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL samersp_req_valid: got %b want 1", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== 32'h200) begin n_bad++; $display("FAIL samersp_req_addr: got %h want 00000200", imem_req_addr); end
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL samersp_fifo_empty: got %b want 0", if_valid); end
    for (int i = 0; i < 100 && pop_q.size() < 3; i++) @(negedge clk);
    n_cmp++; if (pop_q.size() < 3 || pop_q[2].pc !== 32'h200) begin n_bad++; $display("FAIL samersp_if_pc: got n=%0d want third pc 00000200", pop_q.size()); end
  endtask

  task automatic test_wrap();
    int base;
    int idx;
    do_reset(1'b1);
    for (int i = 0; i < 100 && pop_q.size() < 2; i++) @(negedge clk);
    @(posedge clk); #1;
    base = pop_q.size();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    for (int i = 0; i < 100 && pop_q.size() < base + 2; i++) @(negedge clk);
    n_cmp++; if (pop_q.size() < base + 2) begin n_bad++; $display("FAIL wrap_pop_count: got %0d want >=%0d", pop_q.size(), base + 2); end
    else begin
      n_cmp++; if (pop_q[base].pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_pc0: got %h want fffffffc", pop_q[base].pc); end
      n_cmp++; if (pop_q[base].plus4 !== 32'h0) begin n_bad++; $display("FAIL wrap_plus4: got %h want 00000000", pop_q[base].plus4); end
      n_cmp++; if (pop_q[base+1].pc !== 32'h0) begin n_bad++; $display("FAIL wrap_pc1: got %h want 00000000", pop_q[base+1].pc); end
      n_cmp++; if (pop_q[base+1].instr !== mem_word(32'h0)) begin n_bad++; $display("FAIL wrap_instr1: got %h want %h", pop_q[base+1].instr, mem_word(32'h0)); end
    end
    idx = -1;
    foreach (acc_q[i]) if (acc_q[i] === 32'hFFFF_FFFC) idx = i;
    n_cmp++; if (idx < 0 || idx + 1 >= acc_q.size() || acc_q[idx+1] !== 32'h0) begin n_bad++; $display("FAIL wrap_req_addr: got idx=%0d n=%0d want fffffffc then 00000000", idx, acc_q.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    lat_q = '{1, 8};
    for (int i = 0; i < 100 && acc_q.size() < 2; i++) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_req_valid: got %b want 0", imem_req_valid); end
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_if_valid: got %b want 0", if_valid); end
    n_cmp++; if (if_instr !== NOP) begin n_bad++; $display("FAIL midrst_if_instr: got %h want %h", if_instr, NOP); end
    n_cmp++; if (if_pc !== 32'h0) begin n_bad++; $display("FAIL midrst_if_pc: got %h want 0", if_pc); end
    n_cmp++; if (pc_out !== RESET_PC) begin n_bad++; $display("FAIL midrst_pc_out: got %h want %h", pc_out, RESET_PC); end
    repeat (2) @(posedge clk);
    #1;
    acc_q.delete(); pop_q.delete(); lat_q.delete();
    id_ready = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 100 && pop_q.size() < 1; i++) @(negedge clk);
    n_cmp++; if (acc_q.size() < 1 || acc_q[0] !== RESET_PC) begin n_bad++; $display("FAIL midrst_restart_addr: got n=%0d want %h", acc_q.size(), RESET_PC); end
    n_cmp++; if (pop_q.size() < 1 || pop_q[0].pc !== RESET_PC) begin n_bad++; $display("FAIL midrst_restart_pc: got n=%0d want %h", pop_q.size(), RESET_PC); end
  endtask

  // Model: delivered PCs form a +4 stream that restarts at every redirect target.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic        prev_redir;
    int          pops;
    do_reset(1'b1);
    ready_pct = 70; lat_min = 1; lat_max = 4;
    exp_pc = RESET_PC; prev_redir = 1'b0; pops = 0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      id_ready = ($urandom_range(3, 0) != 0);
      if (!prev_redir && $urandom_range(29, 0) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : 32'($urandom);
        exp_pc = redirect_pc & ~32'd3;
      end
      prev_redir = redirect_valid;
      @(negedge clk);
      if (!if_valid) begin
        n_cmp++; if (if_instr !== NOP) begin n_bad++; $display("FAIL rnd_empty_instr: got %h want %h", if_instr, NOP); end
      end else if (id_ready && !redirect_valid) begin
        n_cmp++; if (if_pc !== exp_pc) begin n_bad++; $display("FAIL rnd_if_pc: got %h want %h", if_pc, exp_pc); end
        n_cmp++; if (if_instr !== mem_word(exp_pc)) begin n_bad++; $display("FAIL rnd_if_instr: got %h want %h", if_instr, mem_word(exp_pc)); end
        n_cmp++; if (if_pc_plus4 !== exp_pc + 32'd4) begin n_bad++; $display("FAIL rnd_pc_plus4: got %h want %h", if_pc_plus4, exp_pc + 32'd4); end
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    n_cmp++; if (pops < 100) begin n_bad++; $display("FAIL rnd_progress: got %0d pops want >=100", pops); end
  endtask

  initial begin
    reset = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_drain();
    test_redirect_same_rsp();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
